// File: rtl/pe_lane_mac.sv
// pe_lane_mac: multi-lane signed multiply-accumulate engine.
//
// Each job computes, for every lane l, a dot product of a stream of weight words
// (one weight per lane) with a stream of activations that are broadcast to all
// lanes. The running sum starts from zero (mode 0) or from a partial-sum word
// (mode 1). Weight, activation and partial-sum inputs each pass through their
// own small FIFO, so an upstream producer can prefetch the next job while the
// current result is still waiting to be taken.
//
// Ports:
//   clk             sole clock, rising edge
//   aclr            synchronous active-high reset
//   cfg_len         products per dot product, sampled in IDLE
//   cfg_mode        0 = start from zero, 1 = start from partial sum, sampled in IDLE
//   W_DataIn*       weight stream, Lanes x DataWidth, lane 0 in LSBs
//   I_DataIn*       activation stream, DataWidth, broadcast to all lanes
//   O_DataIn*       partial-sum stream, Lanes x AccWidth, lane 0 in LSBs
//   O_DataOut*      result, Lanes x AccWidth, lane 0 in LSBs; valid/ready handshake

// Small synchronous FIFO with register-array storage. Data at the read pointer
// is presented combinationally so the consumer can use it in the pop cycle.
module pe_lane_fifo #(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  output logic             rdy,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty
);
  localparam int PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
  localparam logic [PtrWidth:0]   CountOne  = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth:0]   CountFull = (PtrWidth + 1)'(Depth);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr_reg;
  logic [PtrWidth-1:0] rd_ptr_reg;
  logic [PtrWidth:0]   count_reg;
  logic [PtrWidth:0]   count_next;
  logic                full;
  logic                do_push;
  logic                do_pop;

  assign full  = (count_reg == CountFull);
  assign empty = (count_reg == '0);
  // Ready depends only on occupancy (never on a same-cycle pop) and is forced
  // low while reset is held.
  assign rdy      = !full && !aclr;
  assign do_push  = push_valid && rdy;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CountOne;
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CountOne;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PtrOne;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PtrOne;
      end
      count_reg <= count_next;
    end
  end

  // Storage has no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end
endmodule

module pe_lane_mac #(
  parameter int DataWidth = 16,
  parameter int AccWidth  = 40,
  parameter int Lanes     = 4,
  parameter int FifoDepth = 4
) (
  input  logic                        clk,
  input  logic                        aclr,
  input  logic [7:0]                  cfg_len,
  input  logic                        cfg_mode,
  input  logic                        W_DataInValid,
  output logic                        W_DataInRdy,
  input  logic [Lanes*DataWidth-1:0]  W_DataIn,
  input  logic                        I_DataInValid,
  output logic                        I_DataInRdy,
  input  logic [DataWidth-1:0]        I_DataIn,
  input  logic                        O_DataInValid,
  output logic                        O_DataInRdy,
  input  logic [Lanes*AccWidth-1:0]   O_DataIn,
  output logic                        O_DataOutValid,
  input  logic                        O_DataOutRdy,
  output logic [Lanes*AccWidth-1:0]   O_DataOut
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic [7:0] len_reg;
  logic [7:0] len_next;
  logic       mode_reg;
  logic       mode_next;
  logic [7:0] count_reg;
  logic [7:0] count_next;
  logic [7:0] count_inc;

  logic [Lanes*AccWidth-1:0] acc_reg;
  logic [Lanes*AccWidth-1:0] acc_next;
  logic acc_clear;
  logic acc_load;
  logic acc_mac;

  logic w_pop;
  logic i_pop;
  logic o_pop;
  logic w_empty;
  logic i_empty;
  logic o_empty;
  logic [Lanes*DataWidth-1:0] w_data;
  logic [DataWidth-1:0]       i_data;
  logic [Lanes*AccWidth-1:0]  o_data;

  pe_lane_fifo #(.Width(Lanes*DataWidth), .Depth(FifoDepth)) u_w_fifo (
    .clk        (clk),
    .aclr       (aclr),
    .push_valid (W_DataInValid),
    .push_data  (W_DataIn),
    .rdy        (W_DataInRdy),
    .pop        (w_pop),
    .pop_data   (w_data),
    .empty      (w_empty)
  );

  pe_lane_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_i_fifo (
    .clk        (clk),
    .aclr       (aclr),
    .push_valid (I_DataInValid),
    .push_data  (I_DataIn),
    .rdy        (I_DataInRdy),
    .pop        (i_pop),
    .pop_data   (i_data),
    .empty      (i_empty)
  );

  pe_lane_fifo #(.Width(Lanes*AccWidth), .Depth(FifoDepth)) u_o_fifo (
    .clk        (clk),
    .aclr       (aclr),
    .push_valid (O_DataInValid),
    .push_data  (O_DataIn),
    .rdy        (O_DataInRdy),
    .pop        (o_pop),
    .pop_data   (o_data),
    .empty      (o_empty)
  );

  assign count_inc = count_reg + 8'd1;

  // Job sequencer. The engine never idles: after a result is taken it returns
  // to IDLE for one cycle, samples the configuration, and starts the next job.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    acc_clear  = 1'b0;
    acc_load   = 1'b0;
    acc_mac    = 1'b0;
    w_pop      = 1'b0;
    i_pop      = 1'b0;
    o_pop      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        len_next   = cfg_len;
        mode_next  = cfg_mode;
        state_next = LOAD;
      end
      LOAD: begin
        if (!mode_reg) begin
          acc_clear  = 1'b1;
          count_next = 8'd0;
          state_next = (len_reg == 8'd0) ? DONE : ACC;
        end else if (!o_empty) begin
          o_pop      = 1'b1;
          acc_load   = 1'b1;
          count_next = 8'd0;
          state_next = (len_reg == 8'd0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (!w_empty && !i_empty) begin
          w_pop      = 1'b1;
          i_pop      = 1'b1;
          acc_mac    = 1'b1;
          count_next = count_inc;
          // Finish on the same edge as the final pop.
          if (count_inc == len_reg) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (O_DataOutRdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-lane datapath: signed product, sign-extended to the accumulator width,
  // summed with natural two's-complement wrap.
  logic signed [DataWidth-1:0] i_data_s;
  assign i_data_s = i_data;

  for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
    logic signed [DataWidth-1:0]   w_lane;
    logic signed [2*DataWidth-1:0] prod;
    logic [AccWidth-1:0]           prod_ext;
    logic [AccWidth-1:0]           acc_lane;
    logic [AccWidth-1:0]           acc_lane_next;

    assign w_lane   = w_data[gi*DataWidth +: DataWidth];
    assign prod     = w_lane * i_data_s;
    assign prod_ext = AccWidth'(prod);
    assign acc_lane = acc_reg[gi*AccWidth +: AccWidth];

    assign acc_lane_next = acc_clear ? '0 :
                           acc_load  ? o_data[gi*AccWidth +: AccWidth] :
                           acc_mac   ? (acc_lane + prod_ext) :
                                       acc_lane;

    assign acc_next[gi*AccWidth +: AccWidth] = acc_lane_next;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_reg <= IDLE;
      len_reg   <= 8'd0;
      mode_reg  <= 1'b0;
      count_reg <= 8'd0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      mode_reg  <= mode_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
    end
  end

  // The accumulator only moves in LOAD/ACC, so the result is inherently
  // stable for as long as DONE is held by backpressure.
  assign O_DataOutValid = (state_reg == DONE);
  assign O_DataOut      = acc_reg;
endmodule

// File: tb/tb_pe_lane_mac.sv
// Testbench for pe_lane_mac: drives jobs through the weight, activation and
// partial-sum streams and checks every result against a dot-product model
// built from the words the design accepted.
module tb_pe_lane_mac;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int LN = 4;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              aclr;
  logic [7:0]        cfg_len;
  logic              cfg_mode;
  logic              W_DataInValid;
  logic              W_DataInRdy;
  logic [LN*DW-1:0]  W_DataIn;
  logic              I_DataInValid;
  logic              I_DataInRdy;
  logic [DW-1:0]     I_DataIn;
  logic              O_DataInValid;
  logic              O_DataInRdy;
  logic [LN*AW-1:0]  O_DataIn;
  logic              O_DataOutValid;
  logic              O_DataOutRdy;
  logic [LN*AW-1:0]  O_DataOut;

  always #5 clk = ~clk;

  pe_lane_mac #(.DataWidth(DW), .AccWidth(AW), .Lanes(LN), .FifoDepth(FD)) dut (
    .clk            (clk),
    .aclr           (aclr),
    .cfg_len        (cfg_len),
    .cfg_mode       (cfg_mode),
    .W_DataInValid  (W_DataInValid),
    .W_DataInRdy    (W_DataInRdy),
    .W_DataIn       (W_DataIn),
    .I_DataInValid  (I_DataInValid),
    .I_DataInRdy    (I_DataInRdy),
    .I_DataIn       (I_DataIn),
    .O_DataInValid  (O_DataInValid),
    .O_DataInRdy    (O_DataInRdy),
    .O_DataIn       (O_DataIn),
    .O_DataOutValid (O_DataOutValid),
    .O_DataOutRdy   (O_DataOutRdy),
    .O_DataOut      (O_DataOut)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cur_mode = 0;
  int cur_len  = 0;

  // Words accepted by the design, in order, still owed to a job.
  logic [LN*DW-1:0] qw[$];
  logic [DW-1:0]    qi[$];
  logic [LN*AW-1:0] qo[$];
  // Words waiting to be offered to the design.
  logic [LN*DW-1:0] stage_w[$];
  logic [DW-1:0]    stage_i[$];
  logic [LN*AW-1:0] stage_o[$];

  logic [LN*AW-1:0] last_exp;

  function automatic logic [LN*DW-1:0] w_rand();
    logic [LN*DW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [LN*AW-1:0] o_rand();
    logic [LN*AW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*AW +: AW] = {8'($urandom), 32'($urandom)};
    return r;
  endfunction

  // Reference: result[l] = start[l] + sum_k W_k[l] * I_k, reduced mod 2^AW.
  task automatic compute_expected(output logic [LN*AW-1:0] exp_v);
    logic [LN*AW-1:0]    ow;
    logic [LN*DW-1:0]    ww;
    logic [DW-1:0]       iw;
    logic signed [AW-1:0] o_l;
    logic signed [DW-1:0] w_l;
    logic signed [DW-1:0] i_l;
    longint sum [LN];
    longint tmp;
    ow = '0;
    if (cur_mode == 1 && qo.size() > 0) ow = qo.pop_front();
    for (int l = 0; l < LN; l++) begin
      o_l = ow[l*AW +: AW];
      sum[l] = longint'(o_l);
    end
    for (int k = 0; k < cur_len; k++) begin
      if (qw.size() == 0 || qi.size() == 0) break;
      ww  = qw.pop_front();
      iw  = qi.pop_front();
      i_l = iw;
      for (int l = 0; l < LN; l++) begin
        w_l = ww[l*DW +: DW];
        sum[l] = sum[l] + longint'(w_l) * longint'(i_l);
      end
    end
    for (int l = 0; l < LN; l++) begin
      tmp = sum[l];
      exp_v[l*AW +: AW] = tmp[AW-1:0];
    end
  endtask

  // Offers staged words on all three streams; a word moves to the model
  // queues only when valid and ready coincide. Called and returns at posedge+1.
  task automatic push_stream(input bit gaps);
    int guard = 0;
    bit wa, ia, oa;
    while ((stage_w.size() > 0 || stage_i.size() > 0 || stage_o.size() > 0) && guard < 2000) begin
      W_DataInValid = 1'b0;
      I_DataInValid = 1'b0;
      O_DataInValid = 1'b0;
      if (stage_w.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        W_DataInValid = 1'b1;
        W_DataIn      = stage_w[0];
      end
      if (stage_i.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        I_DataInValid = 1'b1;
        I_DataIn      = stage_i[0];
      end
      if (stage_o.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        O_DataInValid = 1'b1;
        O_DataIn      = stage_o[0];
      end
      #3;
      wa = W_DataInValid && (W_DataInRdy === 1'b1);
      ia = I_DataInValid && (I_DataInRdy === 1'b1);
      oa = O_DataInValid && (O_DataInRdy === 1'b1);
      @(posedge clk); #1;
      if (wa) qw.push_back(stage_w.pop_front());
      if (ia) qi.push_back(stage_i.pop_front());
      if (oa) qo.push_back(stage_o.pop_front());
      guard++;
    end
    W_DataInValid = 1'b0;
    I_DataInValid = 1'b0;
    O_DataInValid = 1'b0;
    if (guard >= 2000) begin
      n_checks++;
      n_fails++;
      $display("FAIL push_timeout: words left w=%0d i=%0d o=%0d, required 0", stage_w.size(), stage_i.size(), stage_o.size());
      stage_w.delete();
      stage_i.delete();
      stage_o.delete();
    end
  endtask

  task automatic wait_result(input string name, output logic [LN*AW-1:0] exp_v);
    int waited = 0;
    while (O_DataOutValid !== 1'b1 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    compute_expected(exp_v);
    n_checks++;
    if (O_DataOutValid !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_timeout: O_DataOutValid=%b, required 1 within 300 cycles", name, O_DataOutValid);
    end else begin
      n_checks++;
      if (O_DataOut !== exp_v) begin
        n_fails++;
        $display("FAIL %s: O_DataOut=%h required %h", name, O_DataOut, exp_v);
      end else begin
        $display("job %s mode=%0d len=%0d result=%h", name, cur_mode, cur_len, O_DataOut);
      end
    end
  endtask

  // Takes the held result and presents the next job's configuration; returns
  // at posedge+1 of the LOAD cycle, after the configuration has been latched.
  task automatic accept(input int next_mode, input int next_len, input bit scramble);
    cfg_mode     = next_mode[0];
    cfg_len      = next_len[7:0];
    O_DataOutRdy = 1'b1;
    @(posedge clk); #1;
    O_DataOutRdy = 1'b0;
    n_checks++;
    if (O_DataOutValid !== 1'b0) begin
      n_fails++;
      $display("FAIL accept_deassert: O_DataOutValid=%b required 0", O_DataOutValid);
    end
    @(posedge clk); #1;
    cur_mode = next_mode;
    cur_len  = next_len;
    if (scramble) begin
      cfg_mode = ~cfg_mode;
      cfg_len  = cfg_len ^ 8'hA5;
    end
  endtask

  task automatic test_reset();
    aclr          = 1'b1;
    cfg_mode      = 1'b0;
    cfg_len       = 8'd3;
    O_DataOutRdy  = 1'b0;
    W_DataInValid = 1'b1;
    W_DataIn      = w_rand();
    I_DataInValid = 1'b1;
    I_DataIn      = 16'd9;
    O_DataInValid = 1'b1;
    O_DataIn      = o_rand();
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (W_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL reset_w_rdy: %b required 0", W_DataInRdy); end
    if (I_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL reset_i_rdy: %b required 0", I_DataInRdy); end
    if (O_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL reset_o_rdy: %b required 0", O_DataInRdy); end
    if (O_DataOutValid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: %b required 0", O_DataOutValid); end
    if (O_DataOut !== '0) begin n_fails++; $display("FAIL reset_out: %h required 0", O_DataOut); end
    W_DataInValid = 1'b0;
    I_DataInValid = 1'b0;
    O_DataInValid = 1'b0;
    aclr = 1'b0;
    #1;
    n_checks += 3;
    if (W_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL release_w_rdy: %b required 1", W_DataInRdy); end
    if (I_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL release_i_rdy: %b required 1", I_DataInRdy); end
    if (O_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL release_o_rdy: %b required 1", O_DataInRdy); end
    @(posedge clk); #1;
    cur_mode = 0;
    cur_len  = 3;
  endtask

  task automatic test_basic();
    int lat;
    for (int k = 0; k < 3; k++) begin
      stage_w.push_back({LN{16'd5}});
      stage_i.push_back(16'd20);
    end
    push_stream(1'b0);
    wait_result("basic", last_exp);
    for (int l = 0; l < LN; l++) begin
      n_checks++;
      if (O_DataOut[l*AW +: AW] !== 40'd300) begin
        n_fails++;
        $display("FAIL basic_lane%0d: %0d required 300", l, O_DataOut[l*AW +: AW]);
      end
    end
    // Prefill the next job while the result is held, then time it.
    for (int k = 0; k < 3; k++) begin
      stage_w.push_back({LN{16'd5}});
      stage_i.push_back(16'd20);
    end
    push_stream(1'b0);
    accept(0, 3, 1'b1);
    lat = 1;
    while (O_DataOutValid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 5) begin
      n_fails++;
      $display("FAIL latency: %0d cycles required 5", lat);
    end
    wait_result("latency", last_exp);
    accept(1, 1, 1'b1);
  endtask

  task automatic test_mode1();
    stage_o.push_back({LN{40'd100}});
    stage_w.push_back({LN{16'd5}});
    stage_i.push_back(16'd20);
    push_stream(1'b1);
    wait_result("mode1", last_exp);
    for (int l = 0; l < LN; l++) begin
      n_checks++;
      if (O_DataOut[l*AW +: AW] !== 40'd200) begin
        n_fails++;
        $display("FAIL mode1_lane%0d: %0d required 200", l, O_DataOut[l*AW +: AW]);
      end
    end
    accept(1, 0, 1'b1);
  endtask

  // A len-0 job from the partial sum, with the negative-weight job's words
  // already buffered behind it; the second result proves none were consumed.
  task automatic test_len0_negative();
    logic [LN*DW-1:0] ww;
    stage_o.push_back({LN{40'd77}});
    for (int k = 0; k < 2; k++) begin
      ww = w_rand();
      ww[DW-1:0] = 16'hFFFD;
      stage_w.push_back(ww);
      stage_i.push_back(16'd7);
    end
    push_stream(1'b0);
    wait_result("len0", last_exp);
    for (int l = 0; l < LN; l++) begin
      n_checks++;
      if (O_DataOut[l*AW +: AW] !== 40'd77) begin
        n_fails++;
        $display("FAIL len0_lane%0d: %0d required 77", l, O_DataOut[l*AW +: AW]);
      end
    end
    accept(0, 2, 1'b1);
    wait_result("negative", last_exp);
    n_checks++;
    if (O_DataOut[AW-1:0] !== 40'hFFFFFFFFD6) begin
      n_fails++;
      $display("FAIL negative_lane0: %h required ffffffffd6", O_DataOut[AW-1:0]);
    end
  endtask

  // Result held for 5 cycles while the empty weight FIFO is fed 5 words.
  task automatic test_backpressure();
    logic [LN*DW-1:0] ww;
    logic [LN*AW-1:0] held;
    held = last_exp;
    for (int k = 0; k < 5; k++) begin
      ww = w_rand();
      W_DataInValid = 1'b1;
      W_DataIn      = ww;
      #3;
      n_checks += 2;
      if (W_DataInRdy !== ((k < 4) ? 1'b1 : 1'b0)) begin
        n_fails++;
        $display("FAIL bp_w_rdy_%0d: %b required %b", k, W_DataInRdy, (k < 4) ? 1'b1 : 1'b0);
      end
      if (W_DataInRdy === 1'b1) qw.push_back(ww);
      if (O_DataOutValid !== 1'b1 || O_DataOut !== held) begin
        n_fails++;
        $display("FAIL bp_hold_%0d: valid=%b out=%h required valid=1 out=%h", k, O_DataOutValid, O_DataOut, held);
      end
      @(posedge clk); #1;
    end
    W_DataInValid = 1'b0;
    n_checks++;
    if (W_DataInRdy !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_w_full: %b required 0", W_DataInRdy);
    end
    accept(0, 4, 1'b1);
    for (int k = 0; k < 4; k++) stage_i.push_back(DW'($urandom));
    push_stream(1'b1);
    wait_result("bp_len4", last_exp);
    accept(0, 1, 1'b1);
    stage_w.push_back(w_rand());
    stage_i.push_back(DW'($urandom));
    push_stream(1'b1);
    wait_result("after_bp", last_exp);
  endtask

  task automatic test_random();
    int nm, nl;
    for (int j = 0; j < 6; j++) begin
      nm = int'($urandom_range(1));
      nl = int'($urandom_range(8));
      accept(nm, nl, 1'b1);
      if (cur_mode == 1) stage_o.push_back(o_rand());
      for (int k = 0; k < cur_len; k++) begin
        stage_w.push_back(w_rand());
        stage_i.push_back(DW'($urandom));
      end
      push_stream(1'b1);
      wait_result($sformatf("rand%0d", j), last_exp);
    end
  endtask

  task automatic test_abort();
    accept(0, 8, 1'b1);
    for (int k = 0; k < 3; k++) stage_w.push_back(w_rand());
    for (int k = 0; k < 5; k++) stage_i.push_back(DW'($urandom));
    push_stream(1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (O_DataOutValid !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_midjob_valid: %b required 0", O_DataOutValid);
    end
    aclr     = 1'b1;
    cfg_mode = 1'b0;
    cfg_len  = 8'd2;
    @(posedge clk); #1;
    n_checks += 5;
    if (W_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL abort_w_rdy: %b required 0", W_DataInRdy); end
    if (I_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL abort_i_rdy: %b required 0", I_DataInRdy); end
    if (O_DataInRdy !== 1'b0) begin n_fails++; $display("FAIL abort_o_rdy: %b required 0", O_DataInRdy); end
    if (O_DataOutValid !== 1'b0) begin n_fails++; $display("FAIL abort_valid: %b required 0", O_DataOutValid); end
    if (O_DataOut !== '0) begin n_fails++; $display("FAIL abort_out: %h required 0", O_DataOut); end
    @(posedge clk); #1;
    aclr = 1'b0;
    #1;
    n_checks += 3;
    if (W_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL abort_rel_w_rdy: %b required 1", W_DataInRdy); end
    if (I_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL abort_rel_i_rdy: %b required 1", I_DataInRdy); end
    if (O_DataInRdy !== 1'b1) begin n_fails++; $display("FAIL abort_rel_o_rdy: %b required 1", O_DataInRdy); end
    @(posedge clk); #1;
    qw.delete();
    qi.delete();
    qo.delete();
    cur_mode = 0;
    cur_len  = 2;
    for (int k = 0; k < 2; k++) begin
      stage_w.push_back(w_rand());
      stage_i.push_back(DW'($urandom));
    end
    push_stream(1'b1);
    wait_result("post_abort", last_exp);
  endtask

  initial begin
    W_DataInValid = 1'b0;
    W_DataIn      = '0;
    I_DataInValid = 1'b0;
    I_DataIn      = '0;
    O_DataInValid = 1'b0;
    O_DataIn      = '0;
    O_DataOutRdy  = 1'b0;
    aclr          = 1'b1;
    cfg_mode      = 1'b0;
    cfg_len       = 8'd0;
    test_reset();
    test_basic();
    test_mode1();
    test_len0_negative();
    test_backpressure();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/pe_lane_mac.md
PE_LANE_MAC -- requirements
Module: pe_lane_mac

Interface
REQ-001 SHALL have parameter DataWidth, default 16: signed operand width of W and I.
REQ-002 SHALL have parameter AccWidth, default 40: signed accumulator and partial-sum width per lane (AccWidth >= 2*DataWidth).
REQ-003 SHALL have parameter Lanes, default 4: number of parallel MAC lanes.
REQ-004 SHALL have parameter FifoDepth, default 4: entries per input FIFO (power of two, >= 2).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port aclr  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port cfg_len  input  8  products per dot product; sampled in IDLE.
REQ-008 SHALL have port cfg_mode  input  1  0 = start accumulation from zero, 1 = start from O_DataIn partial sum; sampled in IDLE.
REQ-009 SHALL have port W_DataInValid  input  1  weight word valid.
REQ-010 SHALL have port W_DataInRdy  output  1  weight FIFO not full.
REQ-011 SHALL have port W_DataIn  input  Lanes*DataWidth  one weight per lane, lane 0 in LSBs.
REQ-012 SHALL have port I_DataInValid  input  1  input-activation valid.
REQ-013 SHALL have port I_DataInRdy  output  1  input FIFO not full.
REQ-014 SHALL have port I_DataIn  input  DataWidth  activation broadcast to all lanes.
REQ-015 SHALL have port O_DataInValid  input  1  partial-sum word valid.
REQ-016 SHALL have port O_DataInRdy  output  1  partial-sum FIFO not full.
REQ-017 SHALL have port O_DataIn  input  Lanes*AccWidth  partial sum per lane, lane 0 in LSBs.
REQ-018 SHALL have port O_DataOutValid  output  1  result valid.
REQ-019 SHALL have port O_DataOutRdy  input  1  downstream accepts result.
REQ-020 SHALL have port O_DataOut  output  Lanes*AccWidth  result per lane, lane 0 in LSBs.

Function
REQ-021 SHALL buffer W, I and O inputs in three independent registered FIFOs of FifoDepth entries; a word is written when Valid && Rdy and is poppable from the following cycle.
REQ-022 SHALL drive each *_DataInRdy as !full of its FIFO; a write into a full FIFO is never accepted, even when a pop occurs in the same cycle.
REQ-023 SHALL implement states IDLE, LOAD, ACC, DONE; IDLE latches cfg_len/cfg_mode and moves to LOAD next cycle.
REQ-024 LOAD, mode 0: acc[l] := 0 for all lanes, next ACC (or DONE if latched len = 0).
REQ-025 LOAD, mode 1: wait while O FIFO empty; when non-empty pop one word, acc[l] := O[l], next ACC (or DONE if len = 0).
REQ-026 ACC: in any cycle where W and I FIFOs are both non-empty, SHALL pop one word from each and set acc[l] += W[l]*I, count += 1; otherwise hold.
REQ-027 Products SHALL be signed DataWidth x DataWidth, sign-extended to AccWidth; accumulation wraps modulo 2^AccWidth with no saturation or flag.
REQ-028 When count reaches latched len, SHALL enter DONE on the same edge as the final pop; O_DataOutValid = 1 and O_DataOut = acc from that cycle.
REQ-029 DONE: O_DataOut SHALL stay stable while O_DataOutValid && !O_DataOutRdy; on Valid && Rdy, next state IDLE and O_DataOutValid deasserts.
REQ-030 Latency, all FIFOs pre-filled, mode 0, len L: O_DataOutValid rises L+2 cycles after leaving reset-idle (IDLE 1, LOAD 1, ACC L).
REQ-031 FIFO writes SHALL continue in every state, including DONE, so the next job can prefetch.
REQ-032 cfg_len/cfg_mode changes outside IDLE SHALL have no effect on the running job.

Reset
REQ-033 While aclr = 1 at a clock edge: state IDLE, all FIFOs empty, acc and count 0, O_DataOutValid 0, O_DataOut 0.
REQ-034 All *_DataInRdy SHALL be 0 while aclr = 1 and 1 on the first cycle after release.
REQ-035 aclr mid-job SHALL discard partial sums and buffered words; no result is emitted for the aborted job.

Verification
REQ-036 Mode 0, len 3, W all lanes 5, I 20,20,20 -> every lane outputs 300, O_DataOutValid 5 cycles after first job start with FIFOs pre-filled.
REQ-037 Mode 1, O all lanes 100, len 1, W 5, I 20 -> every lane outputs 200; O FIFO empty afterwards.
REQ-038 Mode 0, len 2, W lane0 = 0xFFFD (-3), I 7,7 -> lane0 = 0xFFFFFFFFD6 (-42), other lanes per their weights.
REQ-039 O_DataOutRdy held 0 for 5 cycles in DONE -> output value/valid stable; W pushed 4 more words -> W_DataInRdy falls to 0 after fourth, fifth not accepted.
REQ-040 Mode 1, len 0, O = 77 -> output 77 per lane, no W/I pops; aclr asserted during an ACC of len 8 -> outputs 0, all Rdy 0 then 1, next job correct.
